// File: rtl/ahb_to_apb_bridge_pkg.sv
// Shared encodings and decode helpers for the AHB-lite to APB4 bridge.
package ahb_apb_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [2:0] HSIZE_BYTE = 3'd0;
   localparam logic [2:0] HSIZE_HALF = 3'd1;
   localparam logic [2:0] HSIZE_WORD = 3'd2;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SETUP  = 3'd1,
      ST_ACCESS = 3'd2,
      ST_RESP   = 3'd3,
      ST_ERR1   = 3'd4,
      ST_ERR2   = 3'd5
   } state_t;

   function automatic logic [3:0] pstrb_decode(input logic [2:0] size, input logic [1:0] addr_lo);
      logic [3:0] strb;
      case (size)
         HSIZE_BYTE: strb = 4'b0001 << addr_lo;
         HSIZE_HALF: strb = 4'b0011 << {addr_lo[1], 1'b0};
         HSIZE_WORD: strb = 4'b1111;
         default:    strb = 4'b0000;
      endcase
      return strb;
   endfunction

   function automatic logic misaligned(input logic [2:0] size, input logic [1:0] addr_lo);
      logic bad;
      case (size)
         HSIZE_BYTE: bad = 1'b0;
         HSIZE_HALF: bad = addr_lo[0];
         HSIZE_WORD: bad = |addr_lo;
         default:    bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/ahb_to_apb_bridge.sv
// AHB-lite slave that turns each accepted transfer into one APB4 access,
// stalling HREADYOUT meanwhile and mapping APB errors/timeouts to AHB ERROR.
module ahb_to_apb_bridge
   import ahb_apb_pkg::*;
#(
   parameter int unsigned AW      = 32,
   parameter int unsigned PAW     = 16,
   parameter int unsigned TIMEOUT = 256
) (
   input  logic           HCLK,
   input  logic           HRESET,
   input  logic           HSEL,
   input  logic           HREADY,
   input  logic [AW-1:0]  HADDR,
   input  logic [1:0]     HTRANS,
   input  logic           HWRITE,
   input  logic [2:0]     HSIZE,
   input  logic [31:0]    HWDATA,
   output logic           HREADYOUT,
   output logic [31:0]    HRDATA,
   output logic           HRESP,
   output logic [PAW-1:0] PADDR,
   output logic           PSEL,
   output logic           PENABLE,
   output logic           PWRITE,
   output logic [31:0]    PWDATA,
   output logic [3:0]     PSTRB,
   input  logic [31:0]    PRDATA,
   input  logic           PREADY,
   input  logic           PSLVERR
);

   localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   state_t         state_q, state_d;
   logic [PAW-1:0] paddr_q, paddr_d;
   logic           pwrite_q, pwrite_d;
   logic [3:0]     pstrb_q, pstrb_d;
   logic [31:0]    hrdata_q, hrdata_d;
   logic [CW-1:0]  cnt_q, cnt_d;

   logic htrans_active;
   logic ready_state;
   logic accept;
   logic timeout_hit;
   logic unused_haddr;

   assign unused_haddr = ^HADDR[AW-1:PAW];

   always_comb begin
      case (HTRANS)
         HTRANS_NONSEQ, HTRANS_SEQ: htrans_active = 1'b1;
         HTRANS_IDLE, HTRANS_BUSY:  htrans_active = 1'b0;
      endcase
   end

   assign ready_state = (state_q == ST_IDLE) || (state_q == ST_RESP) || (state_q == ST_ERR2);
   assign accept      = HSEL && HREADY && htrans_active && ready_state;
   // Fires on the last permitted ACCESS cycle, i.e. when this cycle's increment would reach TIMEOUT.
   assign timeout_hit = (TIMEOUT != 0) && !PREADY && (cnt_q == CW'(TIMEOUT - 1));

   always_comb begin
      state_d  = state_q;
      paddr_d  = paddr_q;
      pwrite_d = pwrite_q;
      pstrb_d  = pstrb_q;
      hrdata_d = hrdata_q;
      cnt_d    = cnt_q;

      if (accept) begin
         paddr_d  = HADDR[PAW-1:0];
         pwrite_d = HWRITE;
         pstrb_d  = HWRITE ? pstrb_decode(HSIZE, HADDR[1:0]) : 4'b0000;
      end

      case (state_q)
         ST_IDLE, ST_RESP, ST_ERR2: begin
            if (accept)
               state_d = misaligned(HSIZE, HADDR[1:0]) ? ST_ERR1 : ST_SETUP;
            else
               state_d = ST_IDLE;
         end
         ST_SETUP: begin
            cnt_d   = '0;
            state_d = ST_ACCESS;
         end
         ST_ACCESS: begin
            if (PREADY) begin
               if (!pwrite_q)
                  hrdata_d = PRDATA;
               state_d = PSLVERR ? ST_ERR1 : ST_RESP;
            end else begin
               if (cnt_q != '1)
                  cnt_d = cnt_q + 1'b1;
               if (timeout_hit)
                  state_d = ST_ERR1;
            end
         end
         ST_ERR1: state_d = ST_ERR2;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         state_q  <= ST_IDLE;
         paddr_q  <= '0;
         pwrite_q <= 1'b0;
         pstrb_q  <= '0;
         hrdata_q <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         paddr_q  <= paddr_d;
         pwrite_q <= pwrite_d;
         pstrb_q  <= pstrb_d;
         hrdata_q <= hrdata_d;
         cnt_q    <= cnt_d;
      end
   end

   assign HREADYOUT = ready_state;
   assign HRESP     = (state_q == ST_ERR1) || (state_q == ST_ERR2);
   assign HRDATA    = hrdata_q;
   assign PSEL      = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
   assign PENABLE   = (state_q == ST_ACCESS);
   assign PADDR     = paddr_q;
   assign PWRITE    = pwrite_q;
   assign PSTRB     = pstrb_q;
   assign PWDATA    = HWDATA;

endmodule
